// File: rtl/cache_pkg.sv
// Shared sizing, address-slice and state definitions for the line-refill engine.
package cache_pkg;
  localparam int WORDS   = 8;
  localparam int IDX_W   = 5;
  localparam int TAG_W   = 22;
  localparam int LINE_W  = WORDS * 32;
  localparam int BEAT_W  = $clog2(WORDS);

  localparam int TAG_LSB = 10;
  localparam int IDX_LSB = 5;
  localparam int OFF_LSB = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_FILL  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    FETCH = ST_FETCH,
    FILL  = ST_FILL
  } state_t;
endpackage

// File: rtl/line_assembler.sv
// Beat counter plus per-word slot registers that build up one cache line.
module line_assembler
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              capture,
  input  logic [31:0]       rdata,
  output logic [BEAT_W-1:0] beat,
  output logic              last,
  output logic [LINE_W-1:0] line
);
  logic [BEAT_W-1:0]        beat_q;
  logic [WORDS-1:0][31:0]   slot_q;

  assign beat = beat_q;
  assign last = (beat_q == BEAT_W'(WORDS - 1));
  assign line = slot_q;

  // Counter parks on the last beat; only load moves it back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   beat_q <= '0;
    else if (load)             beat_q <= '0;
    else if (capture && !last) beat_q <= beat_q + 1'b1;
  end

  for (genvar k = 0; k < WORDS; k++) begin : g_slot
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                     slot_q[k] <= '0;
      else if (capture && beat_q == BEAT_W'(k))    slot_q[k] <= rdata;
    end
  end
endmodule

// File: rtl/cache_refill.sv
// Refill engine: fetches eight sequential words for a missed line, then fires one fill/tag write.
module cache_refill
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_req,
  input  logic [31:0]       miss_addr,
  output logic              busy,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              fill,
  output logic [IDX_W-1:0]  idx_mem,
  output logic [LINE_W-1:0] data_mem,
  output logic              tag_we,
  output logic [TAG_W-1:0]  tag_out
);
  state_t                  state_q, state_d;
  logic                    load, capture, last;
  logic [BEAT_W-1:0]       beat;
  logic [31-IDX_LSB:0]     base_q;
  logic [IDX_W-1:0]        idx_q;
  logic [TAG_W-1:0]        tag_q;
  logic                    unused_off;

  // Byte offset within the line never affects which line is fetched.
  assign unused_off = ^miss_addr[IDX_LSB-1:0];

  assign capture = (state_q == FETCH) && mem_ack;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE:    if (miss_req) begin load = 1'b1; state_d = FETCH; end
      FETCH:   if (mem_ack && last) state_d = FILL;
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      idx_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        base_q <= miss_addr[31:IDX_LSB];
        idx_q  <= miss_addr[TAG_LSB-1:IDX_LSB];
        tag_q  <= miss_addr[31:TAG_LSB];
      end
    end
  end

  line_assembler u_asm (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .capture (capture),
    .rdata   (mem_rdata),
    .beat    (beat),
    .last    (last),
    .line    (data_mem)
  );

  assign busy     = (state_q != IDLE);
  assign mem_req  = (state_q == FETCH);
  assign mem_addr = mem_req ? {base_q, beat, {OFF_LSB{1'b0}}} : 32'h0;
  assign fill     = (state_q == FILL);
  assign tag_we   = (state_q == FILL);
  assign idx_mem  = idx_q;
  assign tag_out  = tag_q;
endmodule

// File: tb/tb_cache_refill.sv
// Directed bench for cache_refill: memory responder plus per-scenario checks.
module tb_cache_refill;
  logic         clk = 0, rst = 1;
  logic         miss_req = 0, mem_ack = 0;
  logic [31:0]  miss_addr = 0, mem_rdata = 0;
  logic         busy, mem_req, fill, tag_we;
  logic [31:0]  mem_addr;
  logic [4:0]   idx_mem;
  logic [255:0] data_mem;
  logic [21:0]  tag_out;
  int n_checks = 0, n_fail = 0;

  cache_refill dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
    .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .fill(fill), .idx_mem(idx_mem), .data_mem(data_mem),
    .tag_we(tag_we), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] exp_line(input logic [31:0] b);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = b + k;
    return l;
  endfunction

  // Memory responder: acks every period-th cycle of mem_req, records what it saw.
  task automatic serve(input int period, input logic [31:0] dbase, input bit hold,
                       input bit chg, input logic [31:0] chg_addr,
                       output logic [7:0][31:0] addrs, output int nfill, output int ncyc,
                       output logic [255:0] fline, output logic [4:0] fidx,
                       output logic [21:0] ftag, output bit tagwe_ok, output bit stable);
    int k, w;
    bit seen, have_prev;
    logic [31:0] prev;
    k = 0; w = 0; seen = 0; have_prev = 0; prev = 0;
    addrs = '0; nfill = 0; ncyc = -1; fline = '0; fidx = '0; ftag = '0;
    tagwe_ok = 1; stable = 1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (!hold) miss_req = 0;
      mem_ack = 0;
      if (fill) begin
        nfill++; fline = data_mem; fidx = idx_mem; ftag = tag_out;
        if (!tag_we) tagwe_ok = 0;
        seen = 1; miss_req = 0;
      end else if (tag_we) tagwe_ok = 0;
      if (seen && !busy) begin ncyc = c; break; end
      if (mem_req) begin
        if (have_prev && mem_addr !== prev) stable = 0;
        if (w == period - 1) begin
          mem_ack = 1; mem_rdata = dbase + k;
          if (k < 8) addrs[k] = mem_addr;
          k++; w = 0; have_prev = 0;
        end else begin
          w++; prev = mem_addr; have_prev = 1;
        end
      end
      if (chg && k == 3) miss_addr = chg_addr;
    end
    mem_ack = 0;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    n_checks++; if (busy !== 0 || mem_req !== 0 || fill !== 0 || tag_we !== 0) begin n_fail++; $display("FAIL reset_ctl: got busy=%b req=%b fill=%b twe=%b want all 0", busy, mem_req, fill, tag_we); end
    n_checks++; if (mem_addr !== 0 || idx_mem !== 0 || tag_out !== 0) begin n_fail++; $display("FAIL reset_regs: got addr=%h idx=%h tag=%h want 0", mem_addr, idx_mem, tag_out); end
    n_checks++; if (data_mem !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data_mem); end
    rst = 0;
  endtask

  task automatic test_reset_mid_fetch();
    logic [7:0][31:0] a; int nf, nc; logic [255:0] l; logic [4:0] ix; logic [21:0] tg; bit tw, st;
    bit saw_fill;
    @(negedge clk); miss_addr = 32'h80; miss_req = 1;
    @(negedge clk); miss_req = 0;
    for (int i = 0; i < 3; i++) begin mem_ack = 1; mem_rdata = 32'h11 + i; @(negedge clk); end
    mem_ack = 0; rst = 1; #1;
    n_checks++; if (busy !== 0 || mem_req !== 0) begin n_fail++; $display("FAIL abort_ctl: got busy=%b req=%b want 0 0", busy, mem_req); end
    n_checks++; if (data_mem !== '0) begin n_fail++; $display("FAIL abort_data: got %h want 0", data_mem); end
    @(negedge clk); rst = 0;
    saw_fill = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (fill || busy) saw_fill = 1; end
    n_checks++; if (saw_fill !== 0) begin n_fail++; $display("FAIL abort_nofill: got activity=%b want 0", saw_fill); end
    miss_addr = 32'h40; miss_req = 1;
    serve(1, 32'h500, 0, 0, 0, a, nf, nc, l, ix, tg, tw, st);
    n_checks++; if (a[0] !== 32'h40 || a[7] !== 32'h5C) begin n_fail++; $display("FAIL restart_addr: got %h..%h want 00000040..0000005c", a[0], a[7]); end
    n_checks++; if (nf !== 1 || l !== exp_line(32'h500)) begin n_fail++; $display("FAIL restart_fill: got nfill=%0d line=%h want 1 %h", nf, l, exp_line(32'h500)); end
  endtask

  task automatic test_basic();
    logic [7:0][31:0] a; int nf, nc; logic [255:0] l; logic [4:0] ix; logic [21:0] tg; bit tw, st;
    miss_addr = 32'hFFFFFC24; miss_req = 1;
    serve(1, 32'hA0, 0, 0, 0, a, nf, nc, l, ix, tg, tw, st);
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (a[k] !== 32'hFFFFFC20 + 4*k) begin n_fail++; $display("FAIL basic_addr[%0d]: got %h want %h", k, a[k], 32'hFFFFFC20 + 4*k); end
    end
    n_checks++; if (nf !== 1 || tw !== 1) begin n_fail++; $display("FAIL basic_fill: got nfill=%0d tagwe_ok=%b want 1 1", nf, tw); end
    n_checks++; if (ix !== 5'd1 || tg !== 22'h3FFFFF) begin n_fail++; $display("FAIL basic_idxtag: got idx=%h tag=%h want 01 3fffff", ix, tg); end
    n_checks++; if (l !== exp_line(32'hA0)) begin n_fail++; $display("FAIL basic_data: got %h want %h", l, exp_line(32'hA0)); end
    n_checks++; if (nc !== 10) begin n_fail++; $display("FAIL basic_cycles: got %0d want 10", nc); end
  endtask

  task automatic test_wait_states();
    logic [7:0][31:0] a; int nf, nc; logic [255:0] l; logic [4:0] ix; logic [21:0] tg; bit tw, st;
    miss_addr = 32'h0000_1234; miss_req = 1;
    serve(3, 32'hC0DE0000, 0, 0, 0, a, nf, nc, l, ix, tg, tw, st);
    n_checks++; if (st !== 1) begin n_fail++; $display("FAIL wait_hold: got stable=%b want 1", st); end
    n_checks++; if (a[0] !== 32'h1220 || a[7] !== 32'h123C) begin n_fail++; $display("FAIL wait_addr: got %h..%h want 00001220..0000123c", a[0], a[7]); end
    n_checks++; if (nf !== 1 || l !== exp_line(32'hC0DE0000)) begin n_fail++; $display("FAIL wait_fill: got nfill=%0d line=%h want 1 %h", nf, l, exp_line(32'hC0DE0000)); end
    n_checks++; if (nc !== 26) begin n_fail++; $display("FAIL wait_cycles: got %0d want 26", nc); end
  endtask

  task automatic test_held_req();
    logic [7:0][31:0] a; int nf, nc; logic [255:0] l; logic [4:0] ix; logic [21:0] tg; bit tw, st;
    miss_addr = 32'h100; miss_req = 1;
    serve(1, 32'h300, 1, 1, 32'h200, a, nf, nc, l, ix, tg, tw, st);
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (a[k] !== 32'h100 + 4*k) begin n_fail++; $display("FAIL held_addr[%0d]: got %h want %h", k, a[k], 32'h100 + 4*k); end
    end
    n_checks++; if (ix !== 5'd8 || tg !== 22'h0 || nf !== 1) begin n_fail++; $display("FAIL held_idx: got idx=%h tag=%h nfill=%0d want 08 0 1", ix, tg, nf); end
    @(negedge clk);
    n_checks++; if (busy !== 0) begin n_fail++; $display("FAIL held_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0][31:0] a; int nf1, nf2, nc; logic [255:0] l; logic [4:0] ix; logic [21:0] tg; bit tw, st;
    miss_addr = 32'h1000; miss_req = 1;
    serve(1, 32'h100, 0, 0, 0, a, nf1, nc, l, ix, tg, tw, st);
    miss_addr = 32'h2020; miss_req = 1;
    serve(1, 32'h200, 0, 0, 0, a, nf2, nc, l, ix, tg, tw, st);
    n_checks++; if (nf1 + nf2 !== 2) begin n_fail++; $display("FAIL b2b_fills: got %0d want 2", nf1 + nf2); end
    n_checks++; if (nc !== 10 || a[0] !== 32'h2020) begin n_fail++; $display("FAIL b2b_start: got cycles=%0d addr0=%h want 10 00002020", nc, a[0]); end
    n_checks++; if (ix !== 5'd1 || tg !== 22'h8 || l !== exp_line(32'h200)) begin n_fail++; $display("FAIL b2b_line: got idx=%h tag=%h line=%h want 01 8 %h", ix, tg, l, exp_line(32'h200)); end
  endtask

  task automatic test_stray_ack();
    bit moved;
    moved = 0;
    mem_rdata = 32'hDEAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_ack = 1;
      if (busy || mem_req || fill) moved = 1;
    end
    @(negedge clk); mem_ack = 0;
    if (busy || mem_req || fill) moved = 1;
    n_checks++; if (moved !== 0) begin n_fail++; $display("FAIL stray_state: got activity=%b want 0", moved); end
    n_checks++; if (data_mem !== exp_line(32'h200)) begin n_fail++; $display("FAIL stray_data: got %h want %h", data_mem, exp_line(32'h200)); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_fetch();
    test_basic();
    test_wait_states();
    test_held_req();
    test_back_to_back();
    test_stray_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_refill.md
Name: cache_refill

Overview:
- Line-refill engine that drives the data cache's fill port from the memory side.
- On a miss request it issues eight sequential 32-bit word reads to main memory and assembles them into a 256-bit line.
- When the line is complete it asserts a one-cycle fill, together with the line index and tag, so the cache data array and tag store update in the same cycle.
- It sits between the cache/miss logic and the memory bus, and holds the pipeline stalled via busy.

Parameters:
- WORDS, 8, 32-bit words per line; the line width is WORDS*32.
- IDX_W, 5, line index width, taken from address bits [9:5].
- TAG_W, 22, tag width, taken from address bits [31:10].

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- miss_req  in  1  pulse or level; starts a refill when sampled high in IDLE.
- miss_addr  in  32  byte address of the missing access.
- busy  out  1  high in every state except IDLE.
- mem_req  out  1  read request to memory, held high until acknowledged.
- mem_addr  out  32  word address of the current beat.
- mem_ack  in  1  memory returns mem_rdata this cycle.
- mem_rdata  in  32  returned word.
- fill  out  1  one-cycle write strobe to the cache line array.
- idx_mem  out  IDX_W  line index for the fill.
- data_mem  out  256  assembled line; word k occupies bits [32k+31:32k].
- tag_we  out  1  tag store write strobe, asserted coincident with fill.
- tag_out  out  TAG_W  tag to write.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, beat=0.
  - busy, mem_req, fill and tag_we are 0.
  - mem_addr, idx_mem, tag_out and data_mem are 0.
- IDLE:
  - If miss_req=1, latch base={miss_addr[31:5],5'b0}, idx_mem=miss_addr[9:5], tag_out=miss_addr[31:10] and beat=0, then go to FETCH.
  - busy rises on the next cycle, so there is 1 cycle of latency from miss_req to busy and mem_req.
- FETCH:
  - mem_req=1 and mem_addr=base+4*beat, both stable until mem_ack.
  - On a cycle with mem_ack=1, write mem_rdata into word slot beat.
  - If beat==WORDS-1, go to FILL; otherwise increment beat.
  - mem_ack may be high on consecutive cycles, giving one beat per cycle.
  - mem_req stays high across beats. It drops only on the cycle after the last ack.
- FILL:
  - fill=1 and tag_we=1 for exactly one cycle, with data_mem, idx_mem and tag_out stable.
  - Then go to IDLE. busy falls on the cycle after FILL.
- Minimum refill time: 1 (accept) + 8 (beats) + 1 (FILL) = 10 cycles from miss_req to the return to IDLE.
- Boundary conditions:
  - miss_req while busy: ignored. The latched address and index do not change.
  - mem_ack outside FETCH: ignored, with no data capture.
  - Beat counter: 3 bits, and it never wraps past WORDS-1 into another beat.
  - Assertion of rst during FETCH or FILL: abort immediately to IDLE. The partial line is discarded, and fill is not asserted for it.
  - miss_req on the same cycle busy falls (the IDLE cycle after FILL): accepted normally.
- data_mem holds its last assembled value while in IDLE. It is valid to the cache only when fill=1.

Decomposition:
- Shared package (cache_pkg) holds:
  - WORDS, IDX_W, TAG_W and LINE_W=256.
  - Address slice constants: TAG_LSB=10, IDX_LSB=5, OFF_LSB=2.
  - State encoding IDLE/FETCH/FILL as 2-bit localparams.
- One sub-module, line_assembler: beat counter plus the 256-bit shift/slot register, with load, capture and last outputs.
- The FSM stays in cache_refill.

Test Plan:
- Reset mid-FETCH: after 3 acks, pulse rst → busy=0, mem_req=0 and fill never pulses. Then request 0x00000040 → mem_addr sequence starts again at 0x00000040.
- Basic refill: miss_addr=0xFFFFFC24, memory acks every cycle with data 0xA0+k → mem_addr steps 0xFFFFFC20..0xFFFFFC3C. Fill pulses once with idx_mem=1 and tag_out=22'h3FFFFF. data_mem word k=0xA0+k. Total 10 cycles.
- Wait states: ack only every 3rd cycle → mem_addr holds during waits, fill occurs exactly once after the 8th ack, and data is correct.
- miss_req held high throughout a refill for 0x00000100 while miss_addr changes to 0x00000200 mid-fetch → all beats fetched from 0x100..0x11C and idx_mem=8.
- Back-to-back: second miss_req on the cycle after FILL → second refill starts without a gap, and fill pulses twice in total.
- Stray mem_ack in IDLE with mem_rdata=0xDEAD → no state change and data_mem unchanged.
